// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings, requester IDs and counter sizing for the memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;

   // Smallest width holding 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared instruction/data memory port.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_done;
   logic [DW-1:0] if_rdata;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic          dm_done;
   logic [DW-1:0] dm_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall
   );
endinterface

// File: rtl/mem_port_arbiter_prio_pick.sv
// Winner select: data has priority unless fetch is waiting and the data streak is exhausted.
module arb_prio_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic if_req_i,
   input  logic dm_req_i,
   input  logic streak_full_i,
   output logic vld_o,
   output logic winner_o
);
   assign vld_o    = if_req_i | dm_req_i;
   assign winner_o = (dm_req_i && !(if_req_i && streak_full_i)) ? REQ_DM : REQ_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store onto one memory port, one transaction at a time.
// mem_en one cycle after the IDLE grant; done after MEM_LAT (loads/fetches) or 1 cycle (stores).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int LW = cnt_width(MEM_LAT - 1);
   localparam int SW = cnt_width(MAX_STREAK);

   state_e        state_q, state_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic          pick_vld, pick_win, streak_full, resp;

   assign streak_full = (streak_q == SW'(MAX_STREAK));

   arb_prio_pick u_pick (
      .if_req_i      (bus.if_req),
      .dm_req_i      (bus.dm_req),
      .streak_full_i (streak_full),
      .vld_o         (pick_vld),
      .winner_o      (pick_win)
   );

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      streak_d   = streak_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if (!bus.if_req) streak_d = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               owner_d = pick_win;
               state_d = ST_ISSUE;
               if (pick_win == REQ_DM) begin
                  addr_d  = bus.dm_addr;
                  we_d    = bus.dm_we;
                  wdata_d = bus.dm_wdata;
                  if (bus.if_req && !streak_full) streak_d = streak_q + 1'b1;
               end else begin
                  addr_d   = bus.if_addr;
                  we_d     = 1'b0;
                  streak_d = '0;
               end
            end
         end
         ST_ISSUE: begin
            lat_d   = LW'(MEM_LAT - 1);
            state_d = (we_q || MEM_LAT == 1) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            lat_d = lat_q - 1'b1;
            if (lat_q == LW'(1)) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (!we_q) begin
               if (owner_q == REQ_IF) if_rdata_d = bus.mem_rdata;
               else                   dm_rdata_d = bus.mem_rdata;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         lat_q      <= '0;
         streak_q   <= '0;
         owner_q    <= REQ_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         streak_q   <= streak_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end

   assign resp          = (state_q == ST_RESP);
   assign bus.mem_en    = (state_q == ST_ISSUE);
   assign bus.mem_we    = bus.mem_en & we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_done   = resp && (owner_q == REQ_IF);
   assign bus.dm_done   = resp && (owner_q == REQ_DM);
   assign bus.stall     = bus.if_req & ~bus.if_done;
   // Read data is forwarded during RESP so it is valid alongside done, then held by the register.
   assign bus.if_rdata  = bus.if_done ? bus.mem_rdata : if_rdata_q;
   assign bus.dm_rdata  = (bus.dm_done && !we_q) ? bus.mem_rdata : dm_rdata_q;
endmodule
